// File: rtl/sync_fifo_pkg.sv
// Shared constants and sizing helpers for the single-clock FIFO.
package sync_fifo_pkg;

    // Read-mode selector values for the FWFT parameter.
    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Bits needed to represent an occupancy of 0..depth inclusive.
    function automatic int count_bits(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array: one synchronous enabled write port, one combinational read port.
// Contents are deliberately not reset.
module sync_fifo_mem
#(
    parameter int FIFO_WIDTH = 8,
    parameter int ADDR_WIDTH = 9
)
(
    input  logic                  clk,
    input  logic                  i_wen,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [FIFO_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [FIFO_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [FIFO_WIDTH-1:0] r_mem [DEPTH];

    // Write the incoming word when the controller accepts it.
    always_ff @(posedge clk) begin
        if (i_wen) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Combinational read of the addressed word.
    always_comb begin
        o_rdata = r_mem[i_raddr];
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with standard or first-word-fall-through read, occupancy
// count, almost-full/almost-empty flags, sticky overflow/underflow and a
// synchronous flush.
//
// Handshake: a write is accepted when winc=1 and wfull=0 on a rising edge; a
// read is accepted when rinc=1 and rempty=0 on a rising edge. Both decisions use
// the flags as they stand before that edge, so a full FIFO with winc&rinc reads
// only and an empty FIFO with winc&rinc writes only.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 9,
    parameter int FWFT          = FIFO_MODE_STD,
    parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
    parameter int AEMPTY_THRESH = 4
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  winc,
    input  logic [FIFO_WIDTH-1:0] wdata,
    input  logic                  rinc,
    output logic [FIFO_WIDTH-1:0] rdata,
    output logic                  wfull,
    output logic                  rempty,
    output logic                  walmost_full,
    output logic                  ralmost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = count_bits(DEPTH);

    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

    // Reject parameter sets that cannot work at elaboration time.
    if (ADDR_WIDTH < 1) begin : g_bad_addr
        $error("sync_fifo: ADDR_WIDTH must be at least 1");
    end
    if (CNT_W != ADDR_WIDTH + 1) begin : g_bad_cnt
        $error("sync_fifo: count width does not match ADDR_WIDTH+1");
    end
    if (!(AEMPTY_THRESH >= 0 && AEMPTY_THRESH < AFULL_THRESH && AFULL_THRESH <= DEPTH)) begin : g_bad_thresh
        $error("sync_fifo: need 0 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
    end
    if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
        $error("sync_fifo: FWFT must be 0 or 1");
    end

    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_wfull;
    logic                  w_rempty;
    logic                  w_wacc;
    logic                  w_racc;
    logic [FIFO_WIDTH-1:0] w_mem_rdata;

    // Status flags decoded purely from the registered count.
    always_comb begin
        w_wfull       = (r_count == DEPTH_C);
        w_rempty      = (r_count == '0);
        walmost_full  = (r_count >= AFULL_C);
        ralmost_empty = (r_count <= AEMPTY_C);
    end

    // Accept decisions; a flush suppresses both so nothing moves that cycle.
    always_comb begin
        w_wacc = winc & ~w_wfull  & ~clear;
        w_racc = rinc & ~w_rempty & ~clear;
    end

    // Write and read pointers, wrapping naturally modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (clear) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wacc) r_wptr <= r_wptr + 1'b1;
            if (w_racc) r_rptr <= r_rptr + 1'b1;
        end
    end

    // Occupancy: moves only when exactly one side is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (w_wacc && !w_racc) begin
            r_count <= r_count + 1'b1;
        end else if (w_racc && !w_wacc) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Sticky error flags: any request against the wrong flag, held until flush/reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clear) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (winc && w_wfull)  r_overflow  <= 1'b1;
            if (rinc && w_rempty) r_underflow <= 1'b1;
        end
    end

    sync_fifo_mem #(
        .FIFO_WIDTH (FIFO_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .i_wen   (w_wacc),
        .i_waddr (r_wptr),
        .i_wdata (wdata),
        .i_raddr (r_rptr),
        .o_rdata (w_mem_rdata)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Head word is shown directly; meaningless while empty.
        always_comb begin
            rdata = w_mem_rdata;
        end
    end else begin : g_std
        logic [FIFO_WIDTH-1:0] r_rdata;

        // Registered read: capture the head word on an accepted pop, else hold.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rdata <= '0;
            end else if (w_racc) begin
                r_rdata <= w_mem_rdata;
            end
        end

        // Present the registered word.
        always_comb begin
            rdata = r_rdata;
        end
    end

    // Drive the remaining outputs from their registers.
    always_comb begin
        wfull     = w_wfull;
        rempty    = w_rempty;
        count     = r_count;
        overflow  = r_overflow;
        underflow = r_underflow;
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a standard-mode and an FWFT instance, both
// depth 4 with almost-full at 3 and almost-empty at 1.
module tb_sync_fifo;

  localparam int W  = 8;
  localparam int AW = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // standard-mode instance signals
  logic          s_clear = 1'b0, s_winc = 1'b0, s_rinc = 1'b0;
  logic [W-1:0]  s_wdata = '0;
  logic [W-1:0]  s_rdata;
  logic          s_wfull, s_rempty, s_afull, s_aempty, s_ovf, s_udf;
  logic [AW:0]   s_count;

  // FWFT instance signals
  logic          f_clear = 1'b0, f_winc = 1'b0, f_rinc = 1'b0;
  logic [W-1:0]  f_wdata = '0;
  logic [W-1:0]  f_rdata;
  logic          f_wfull, f_rempty, f_afull, f_aempty, f_ovf, f_udf;
  logic [AW:0]   f_count;

  sync_fifo #(
    .FIFO_WIDTH(W), .ADDR_WIDTH(AW), .FWFT(0), .AFULL_THRESH(3), .AEMPTY_THRESH(1)
  ) u_std (
    .clk(clk), .rst(rst), .clear(s_clear), .winc(s_winc), .wdata(s_wdata),
    .rinc(s_rinc), .rdata(s_rdata), .wfull(s_wfull), .rempty(s_rempty),
    .walmost_full(s_afull), .ralmost_empty(s_aempty), .count(s_count),
    .overflow(s_ovf), .underflow(s_udf)
  );

  sync_fifo #(
    .FIFO_WIDTH(W), .ADDR_WIDTH(AW), .FWFT(1), .AFULL_THRESH(3), .AEMPTY_THRESH(1)
  ) u_fwft (
    .clk(clk), .rst(rst), .clear(f_clear), .winc(f_winc), .wdata(f_wdata),
    .rinc(f_rinc), .rdata(f_rdata), .wfull(f_wfull), .rempty(f_rempty),
    .walmost_full(f_afull), .ralmost_empty(f_aempty), .count(f_count),
    .overflow(f_ovf), .underflow(f_udf)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic s_idle();
    s_winc = 1'b0; s_rinc = 1'b0; s_clear = 1'b0;
  endtask

  // Pop one word in standard mode and compare against the expected queue.
  task automatic s_pop(input string tag);
    logic [W-1:0] e;
    s_winc = 1'b0; s_rinc = 1'b1;
    step();
    e = exp_q.pop_front();
    check_eq(tag, 32'(s_rdata), 32'(e));
  endtask

  // Flag bundle {wfull, rempty, afull, aempty} of the standard instance.
  function automatic logic [3:0] s_flags();
    return {s_wfull, s_rempty, s_afull, s_aempty};
  endfunction

  logic [W-1:0] wr_vec [4];
  logic [AW:0]  cnt_vec [4];
  logic [3:0]   flg_vec [4];

  initial begin
    wr_vec  = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    cnt_vec = '{3'd1, 3'd2, 3'd3, 3'd4};
    // {wfull, rempty, afull, aempty} after each write
    flg_vec = '{4'b0001, 4'b0000, 4'b0010, 4'b1010};

    // ---- reset state ----
    #2;
    check_eq("rst_flags", 32'(s_flags()), 32'b0101);
    check_eq("rst_count", 32'(s_count), 32'd0);
    check_eq("rst_rdata", 32'(s_rdata), 32'd0);
    check_eq("rst_err",   32'({s_ovf, s_udf}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // ---- 1: fill to full ----
    for (int i = 0; i < 4; i++) begin
      s_winc = 1'b1; s_wdata = wr_vec[i];
      exp_q.push_back(wr_vec[i]);
      step();
      check_eq($sformatf("fill_count%0d", i), 32'(s_count), 32'(cnt_vec[i]));
      check_eq($sformatf("fill_flags%0d", i), 32'(s_flags()), 32'(flg_vec[i]));
    end

    // ---- 2: overflow, then drain ----
    s_wdata = 8'hFF;
    step();
    check_eq("ovf_set",   32'(s_ovf),   32'd1);
    check_eq("ovf_count", 32'(s_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      s_pop($sformatf("drain%0d", i));
      check_eq($sformatf("drain_count%0d", i), 32'(s_count), 32'(3 - i));
    end
    check_eq("drain_empty", 32'(s_rempty), 32'd1);

    // ---- 3: underflow, then simultaneous on empty ----
    s_pop_empty: begin
      s_rinc = 1'b1; s_winc = 1'b0;
      step();
      check_eq("udf_set",   32'(s_udf),   32'd1);
      check_eq("udf_count", 32'(s_count), 32'd0);
      check_eq("udf_rdata", 32'(s_rdata), 32'hA4);
    end
    s_winc = 1'b1; s_rinc = 1'b1; s_wdata = 8'hB1;
    exp_q.push_back(8'hB1);
    step();
    check_eq("both_empty_count", 32'(s_count), 32'd1);
    check_eq("both_empty_udf",   32'(s_udf),   32'd1);
    check_eq("both_empty_rdata", 32'(s_rdata), 32'hA4);

    // ---- 4: steady state at count 2 across pointer wrap ----
    s_rinc = 1'b0; s_wdata = 8'hB2;
    exp_q.push_back(8'hB2);
    step();
    check_eq("pre_wrap_count", 32'(s_count), 32'd2);
    for (int i = 0; i < 5; i++) begin
      logic [W-1:0] e;
      s_winc = 1'b1; s_rinc = 1'b1; s_wdata = 8'hC1 + 8'(i);
      exp_q.push_back(s_wdata);
      step();
      e = exp_q.pop_front();
      check_eq($sformatf("wrap_rdata%0d", i), 32'(s_rdata), 32'(e));
      check_eq($sformatf("wrap_count%0d", i), 32'(s_count), 32'd2);
    end

    // ---- 6a: clear beats winc ----
    s_rinc = 1'b0; s_winc = 1'b1; s_wdata = 8'hC6;
    step();
    check_eq("pre_clr_count", 32'(s_count), 32'd3);
    check_eq("pre_clr_ovf",   32'(s_ovf),   32'd1);
    s_clear = 1'b1; s_winc = 1'b1; s_wdata = 8'hEE;
    step();
    s_idle();
    exp_q.delete();
    check_eq("clr_count", 32'(s_count), 32'd0);
    check_eq("clr_err",   32'({s_ovf, s_udf}), 32'd0);
    check_eq("clr_flags", 32'(s_flags()), 32'b0101);
    check_eq("clr_rdata", 32'(s_rdata), 32'hC3);
    // Pointers restart at zero: the next written word is the next one read.
    s_winc = 1'b1; s_wdata = 8'hD1;
    exp_q.push_back(8'hD1);
    step();
    s_pop("post_clr_pop");
    check_eq("post_clr_count", 32'(s_count), 32'd0);

    // ---- 5: FWFT fall-through ----
    f_winc = 1'b1; f_wdata = 8'h5A;
    step();
    f_winc = 1'b0;
    check_eq("fwft_rdata",  32'(f_rdata),  32'h5A);
    check_eq("fwft_rempty", 32'(f_rempty), 32'd0);
    step();
    check_eq("fwft_hold",   32'(f_rdata),  32'h5A);
    f_rinc = 1'b1;
    step();
    f_rinc = 1'b0;
    check_eq("fwft_pop_empty", 32'(f_rempty), 32'd1);
    check_eq("fwft_pop_count", 32'(f_count),  32'd0);
    f_winc = 1'b1; f_wdata = 8'h11;
    step();
    f_wdata = 8'h22;
    step();
    f_winc = 1'b0;
    check_eq("fwft_head1", 32'(f_rdata), 32'h11);
    f_rinc = 1'b1;
    step();
    f_rinc = 1'b0;
    check_eq("fwft_head2", 32'(f_rdata), 32'h22);
    check_eq("fwft_count", 32'(f_count), 32'd1);

    // ---- 6b: asynchronous reset mid-burst ----
    s_idle();
    for (int i = 0; i < 5; i++) begin
      s_winc = 1'b1; s_wdata = 8'h70 + 8'(i);
      step();
    end
    s_winc = 1'b0; s_rinc = 1'b1;
    step();
    check_eq("burst_rdata", 32'(s_rdata), 32'h70);
    check_eq("burst_ovf",   32'(s_ovf),   32'd1);
    s_winc = 1'b1; s_rinc = 1'b1; s_wdata = 8'h99;
    #2 rst = 1'b1;
    #1;
    check_eq("arst_count", 32'(s_count), 32'd0);
    check_eq("arst_flags", 32'(s_flags()), 32'b0101);
    check_eq("arst_rdata", 32'(s_rdata), 32'd0);
    check_eq("arst_err",   32'({s_ovf, s_udf}), 32'd0);
    check_eq("arst_fwft_count", 32'(f_count), 32'd0);
    s_idle();
    step();
    rst = 1'b0;

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Backstop so the run always ends even if the sequence stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock, parametrised FIFO. It is the same-clock-domain counterpart of the dual-clock FIFO already in the codebase. Over that block it adds:
- a selectable standard or first-word-fall-through (FWFT) read mode
- an occupancy count
- programmable almost-full and almost-empty flags
- sticky overflow and underflow error flags
- a synchronous flush

It is used for buffering inside a single clock domain.

Parameters:
FIFO_WIDTH, 8, data word width in bits.
ADDR_WIDTH, 9, address bits; DEPTH = 1<<ADDR_WIDTH (minimum ADDR_WIDTH 1).
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through.
AFULL_THRESH, DEPTH-4, walmost_full asserts when count >= this value.
AEMPTY_THRESH, 4, ralmost_empty asserts when count <= this value.

Ports:
clk  input  1  single clock; all logic is on the rising edge.
rst  input  1  asynchronous, active-high reset.
clear  input  1  synchronous flush.
winc  input  1  write request.
wdata  input  FIFO_WIDTH  write data.
rinc  input  1  read request (pop).
rdata  output  FIFO_WIDTH  read data.
wfull  output  1  FIFO holds DEPTH words.
rempty  output  1  FIFO holds 0 words.
walmost_full  output  1  count >= AFULL_THRESH.
ralmost_empty  output  1  count <= AEMPTY_THRESH.
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
overflow  output  1  sticky: a write was attempted while full.
underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (rst=1, asynchronous): write pointer, read pointer and count are 0. Outputs reset as follows: rempty=1, wfull=0, ralmost_empty=1, walmost_full=0, overflow=0, underflow=0, rdata=0. Memory contents are not reset.
- Pointers are binary, ADDR_WIDTH bits wide, and wrap modulo DEPTH. count is a separate ADDR_WIDTH+1-bit register.
- Flags are decoded from the count register only, so they reflect state after the last clock edge:
  - wfull = (count==DEPTH)
  - rempty = (count==0)
  - walmost_full = (count>=AFULL_THRESH)
  - ralmost_empty = (count<=AEMPTY_THRESH)
- Write accept: wacc = winc & ~wfull. On wacc, mem[wptr] <= wdata and wptr increments.
- Read accept: racc = rinc & ~rempty. On racc, rptr increments.
- Both accepts are evaluated against the current flags:
  - Full with winc and rinc both high: read only; write is dropped; overflow is set.
  - Empty with winc and rinc both high: write only; read is ignored; underflow is set.
- count update: +1 on wacc only, -1 on racc only, unchanged when both or neither occur.
- overflow is set by winc & wfull; underflow is set by rinc & rempty. Both hold until rst or clear.
- Standard mode (FWFT=0):
  - On racc, rdata <= mem[rptr]; the word is valid the cycle after the rinc edge (1-cycle latency).
  - rdata holds its value otherwise, including when empty.
- FWFT mode (FWFT=1):
  - rdata = mem[rptr] combinationally. It is the head word whenever rempty=0 and is undefined when empty.
  - rinc consumes the displayed word.
  - Write-to-visible latency: a word written at edge N into an empty FIFO appears at rdata with rempty=0 after edge N.
- clear (synchronous) has priority over winc and rinc in the same cycle:
  - pointers and count go to 0; overflow and underflow clear; flags follow from count.
  - Memory and standard-mode rdata are unchanged.
- Reset mid-operation discards all contents immediately and asynchronously.
- Thresholds are elaboration-time constants. The elaboration check is 0 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH; a violation raises an $error.

Decomposition:
- Package sync_fifo_pkg holds the read-mode constants (FIFO_MODE_STD=0, FIFO_MODE_FWFT=1) and a function clog2-based helper for sizing count.
- One sub-module, sync_fifo_mem:
  - DEPTH x FIFO_WIDTH array
  - one synchronous write port gated by an enable
  - one combinational read port
- Pointer, count, flag and error logic live in sync_fifo.

Test Plan:
1. Params ADDR_WIDTH=2, FWFT=0, AFULL=3, AEMPTY=1. After rst, write 0xA1,0xA2,0xA3,0xA4 -> count steps 1,2,3,4; walmost_full at count 3; wfull at count 4; rempty=0 after the first edge.
2. From full, assert winc with wdata=0xFF -> overflow=1, count stays 4. Then pop 4 times -> rdata is 0xA1..0xA4, each one cycle after its rinc; rempty=1 at count 0.
3. Empty FIFO, assert rinc -> underflow=1, count=0, rdata unchanged. Then winc and rinc together while empty -> count=1, underflow stays 1.
4. Count=2, winc and rinc together for 5 cycles -> count stays 2, read order preserved across pointer wrap.
5. FWFT=1: write 0x5A into an empty FIFO -> rdata=0x5A and rempty=0 after that edge with no rinc; rinc pops it -> rempty=1.
6. Count=3 with overflow set; assert clear together with winc -> count=0, overflow=0, rempty=1, no write. Assert rst mid-burst -> all outputs return to reset values at once.
